// File: rtl/shift_desloc_unit.sv
// shift_desloc_unit: one-bit-per-clock shifter (sll/srl/sra/ror) with Busy and a Done pulse
module shift_desloc_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [4:0]       N,
  input  logic [WIDTH-1:0] Entrada,
  output logic [WIDTH-1:0] RegDeslocOut,
  output logic             Busy,
  output logic             Done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] step;
  logic [4:0]       count;
  logic [1:0]       op_reg;
  always_comb
    step = op_reg == 2'b00 ? {result[WIDTH-2:0], 1'b0} :
           op_reg == 2'b01 ? {1'b0, result[WIDTH-1:1]} :
           op_reg == 2'b10 ? {result[WIDTH-1], result[WIDTH-1:1]} :
                             {result[0], result[WIDTH-1:1]};
  // Busy/Done are registered alongside state so they are glitch-free Moore outputs
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state  <= IDLE;
      result <= '0;
      count  <= '0;
      op_reg <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          result <= Entrada;
          count  <= N;
          op_reg <= Op;
          state  <= N != 5'd0 ? SHIFT : DONE;
          Busy   <= 1'b1;
          Done   <= N == 5'd0;
        end
        SHIFT: begin
          result <= step;
          count  <= count - 5'd1;
          if (count == 5'd1) begin
            state <= DONE;
            Done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  assign RegDeslocOut = result;
endmodule

// File: tb/tb_shift_desloc_unit.sv
// tb_shift_desloc_unit: directed and random checks of shift_desloc_unit against a cycle-count model
module tb_shift_desloc_unit;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = '0;
  logic [4:0]  N = '0;
  logic [31:0] Entrada = '0;
  logic [31:0] RegDeslocOut;
  logic        Busy, Done;
  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  shift_desloc_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .N(N),
    .Entrada(Entrada), .RegDeslocOut(RegDeslocOut), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // value of the operand after k single-bit steps, as closed-form arithmetic
  function automatic logic [31:0] shf(input logic [31:0] x, input logic [1:0] op, input int k);
    case (op)
      2'd0: return x << k;
      2'd1: return x >> k;
      2'd2: return 32'($signed(x) >>> k);
      default: return k == 0 ? x : (x >> k) | (x << (32 - k));
    endcase
  endfunction

  // model: an operation is active from the cycle after acceptance for n+1 cycles
  bit          m_act = 0;
  logic [31:0] m_x = '0;
  logic [1:0]  m_op = '0;
  int          m_n = 0;
  int          m_k = 0;
  always @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      m_act <= 0; m_x <= '0; m_op <= '0; m_n <= 0; m_k <= 0;
    end else if (m_act) begin
      m_k <= m_k + 1;
      if (m_k == m_n) m_act <= 0;
    end else if (Start) begin
      m_act <= 1; m_x <= Entrada; m_op <= Op; m_n <= int'(N); m_k <= 0;
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk)
    if (chk_en) begin
      chk("cyc_out", RegDeslocOut, shf(m_x, m_op, m_k < m_n ? m_k : m_n));
      chk("cyc_busy", 32'(Busy), 32'(m_act));
      chk("cyc_done", 32'(Done), 32'(m_act && m_k == m_n));
    end

  task automatic start_op(input logic [1:0] op, input logic [4:0] n, input logic [31:0] x);
    @(posedge Clk); #1;
    Start = 1'b1; Op = op; N = n; Entrada = x;
    @(posedge Clk); #1;
    Start = 1'b0; Op = 2'($urandom); N = 5'($urandom); Entrada = $urandom;
  endtask

  // cycle number counted from the Start cycle (0); returns where Done was seen
  task automatic wait_done(input int c0, input int max, output int c);
    c = c0;
    while (!Done && c < max) begin
      @(posedge Clk); #1;
      c++;
    end
    if (!Done) begin
      total++; bad++;
      $display("FAIL done_timeout: no Done by cycle %0d", c);
    end
  endtask

  initial begin
    int c;
    chk("pin_sll", shf(32'h1, 2'd0, 4), 32'h10);
    chk("pin_sra", shf(32'h80000000, 2'd2, 31), 32'hFFFFFFFF);
    chk("pin_ror", shf(32'h3, 2'd3, 1), 32'h80000001);
    #1 Reset_n = 1'b0;
    #1 chk_en = 1;
    repeat (2) @(posedge Clk);
    #2 Reset_n = 1'b1;
    chk("reset_out", RegDeslocOut, 32'h0);
    chk("reset_busy", 32'(Busy), 32'h0);

    start_op(2'd0, 5'd4, 32'h1);
    wait_done(1, 40, c);
    chk("sll_cycle", c, 5);
    chk("sll_val", RegDeslocOut, 32'h10);
    @(posedge Clk); #1;
    chk("sll_busy_fall", 32'(Busy), 32'h0);

    start_op(2'd2, 5'd31, 32'h80000000);
    wait_done(1, 40, c);
    chk("sra_cycle", c, 32);
    chk("sra_val", RegDeslocOut, 32'hFFFFFFFF);
    start_op(2'd1, 5'd31, 32'h80000000);
    wait_done(1, 40, c);
    chk("srl_val", RegDeslocOut, 32'h1);
    start_op(2'd3, 5'd1, 32'h3);
    wait_done(1, 40, c);
    chk("ror_cycle", c, 2);
    chk("ror_val", RegDeslocOut, 32'h80000001);
    start_op(2'd0, 5'd0, 32'hDEADBEEF);
    wait_done(1, 40, c);
    chk("n0_cycle", c, 1);
    chk("n0_val", RegDeslocOut, 32'hDEADBEEF);

    start_op(2'd0, 5'd8, 32'h1);
    repeat (2) begin @(posedge Clk); #1; end
    Start = 1'b1; N = 5'd1; Entrada = 32'hFFFFFFFF;
    @(posedge Clk); #1;
    Start = 1'b0;
    wait_done(4, 40, c);
    chk("ign_cycle", c, 9);
    chk("ign_val", RegDeslocOut, 32'h100);
    Start = 1'b1; N = 5'd1; Entrada = 32'hFFFFFFFF;
    @(posedge Clk); #1;
    Start = 1'b0;
    chk("ign_busy", 32'(Busy), 32'h0);
    repeat (3) @(posedge Clk);
    #1 chk("ign_val_hold", RegDeslocOut, 32'h100);

    start_op(2'd1, 5'd20, 32'hF0000000);
    repeat (4) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(Busy), 32'h0);
    chk("rst_mid_done", 32'(Done), 32'h0);
    chk("rst_mid_out", RegDeslocOut, 32'h0);
    @(posedge Clk); #2 Reset_n = 1'b1;
    start_op(2'd0, 5'd2, 32'h1);
    wait_done(1, 40, c);
    chk("post_rst_cycle", c, 3);
    chk("post_rst_val", RegDeslocOut, 32'h4);

    repeat (10) begin
      @(posedge Clk); #1;
      Entrada = $urandom; N = 5'($urandom);
      chk("hold_done", 32'(Done), 32'h0);
    end
    chk("hold_val", RegDeslocOut, 32'h4);

    repeat (1500) begin
      @(posedge Clk); #1;
      Start = $urandom_range(0, 2) == 0;
      Op = 2'($urandom);
      N = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'($urandom_range(0, 4));
      Entrada = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        #2 Reset_n = 1'b0;
        #1 Reset_n = 1'b1;
      end
    end
    Start = 1'b0;
    repeat (40) @(posedge Clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
